// File: rtl/pcie_cpl_cq_post_pkg.sv
// Shared constants, state encoding and flat-bus helpers for NVMe CQ posting.
// Imported by pcie_cq_tail_slot and pcie_cpl_cq_post.
`ifndef PCIE_CPL_CQ_POST_PKG_SV
`define PCIE_CPL_CQ_POST_PKG_SV

// Byte lane n of a flat 8b-per-CQ bus, and element n of a w-wide flat bus.
`define CQ_B8(n) (8*(n)) +: 8
`define CQ_BW(n, w) ((w)*(n)) +: (w)

package pcie_cpl_cq_post_pkg;

    localparam int C_CQ_NUM          = 9;
    localparam int CQ_ENTRY_DW_SHIFT = 2;

    localparam int ST_IDLE   = 0;
    localparam int ST_CHECK  = 1;
    localparam int ST_CALC   = 2;
    localparam int ST_REQ    = 3;
    localparam int ST_UPDATE = 4;

    typedef enum logic [4:0] {
        S_IDLE   = 5'b00001,
        S_CHECK  = 5'b00010,
        S_CALC   = 5'b00100,
        S_REQ    = 5'b01000,
        S_UPDATE = 5'b10000
    } cq_post_state_e;

endpackage

`endif

// File: rtl/pcie_cq_tail_slot.sv
// Tail pointer and phase tag of one completion queue, plus its full flag.
// Ports: clk_i, rst_n_i (async, active-low), upd_i advance strobe,
// size_i last index, head_i host head; tail_o, phase_o, full_o.
module pcie_cq_tail_slot
    import pcie_cpl_cq_post_pkg::*;
(
    input  logic       clk_i,
    input  logic       rst_n_i,
    input  logic       upd_i,
    input  logic [7:0] size_i,
    input  logic [7:0] head_i,
    output logic [7:0] tail_o,
    output logic       phase_o,
    output logic       full_o
);

    logic [7:0] tail_q;
    logic [7:0] tail_d;
    logic       phase_q;
    logic       phase_d;
    logic       wrap;

    assign wrap    = (tail_q == size_i);
    assign tail_d  = wrap ? 8'd0 : tail_q + 8'd1;
    assign phase_d = wrap ? ~phase_q : phase_q;

    // One slot is always left unused so full and empty stay distinct.
    assign full_o  = (tail_d == head_i);
    assign tail_o  = tail_q;
    assign phase_o = phase_q;

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            tail_q  <= 8'd0;
            phase_q <= 1'b1;
        end else if (upd_i) begin
            tail_q  <= tail_d;
            phase_q <= phase_d;
        end
    end

endmodule

// File: rtl/pcie_cpl_cq_post.sv
// Posts NVMe completion entries to host CQs (CQ0 admin, CQ1-8 I/O).
// Ports: cpl_req/cpl_qid/cpl_rdy request side, tx_cq_* write request to
// the TX engine, per-CQ config/doorbell inputs, tail/irq/error outputs.
module pcie_cpl_cq_post
    import pcie_cpl_cq_post_pkg::*;
#(
    parameter int C_PCIE_DATA_WIDTH = 512,
    parameter int C_PCIE_ADDR_WIDTH = 48,
    parameter int C_CQ_NUM          = pcie_cpl_cq_post_pkg::C_CQ_NUM
) (
    input  logic                                     pcie_user_clk,
    input  logic                                     pcie_user_rst_n,
    input  logic [C_CQ_NUM-1:0]                      cq_rst_n,
    input  logic [C_CQ_NUM-1:0]                      cq_valid,
    input  logic [8*C_CQ_NUM-1:0]                    cq_size_flat,
    input  logic [8*C_CQ_NUM-1:0]                    cq_head_ptr_flat,
    input  logic [C_CQ_NUM*(C_PCIE_ADDR_WIDTH-2)-1:0] cq_bs_addr_flat,
    input  logic                                     cpl_req,
    input  logic [3:0]                               cpl_qid,
    output logic                                     cpl_rdy,
    output logic                                     tx_cq_req,
    output logic [3:0]                               tx_cq_qid,
    output logic [C_PCIE_ADDR_WIDTH-3:0]             tx_cq_addr,
    output logic                                     tx_cq_phase,
    input  logic                                     tx_cq_ack,
    output logic [8*C_CQ_NUM-1:0]                    cq_tail_ptr_flat,
    output logic [C_CQ_NUM-1:0]                      cq_irq_pulse,
    output logic                                     cpl_err
);

    localparam int AD = C_PCIE_ADDR_WIDTH - 2;
    localparam logic [3:0] QID_LAST = 4'(C_CQ_NUM - 1);

    // The data width only sizes the TX datapath elsewhere; reject
    // configurations the TX engine cannot carry.
    if ((C_PCIE_DATA_WIDTH % 128) != 0 || C_CQ_NUM > 16) begin : g_param_chk
        $error("pcie_cpl_cq_post: unsupported parameters");
    end

    cq_post_state_e state_q;

    logic [3:0]    qid_q;
    logic          rdy_q;
    logic          req_q;
    logic [AD-1:0] addr_q;
    logic          phase_q;
    logic          err_q;
    logic          skip_q;
    logic [C_CQ_NUM-1:0] irq_q;

    logic          qid_ok;
    logic [3:0]    sel;
    logic          live;
    logic          upd_en;
    logic [C_CQ_NUM-1:0] sel_oh;
    logic [C_CQ_NUM-1:0] slot_rst_n;
    logic [C_CQ_NUM-1:0] slot_upd;
    logic [C_CQ_NUM-1:0] slot_phase;
    logic [C_CQ_NUM-1:0] slot_full;
    logic [7:0]          slot_tail [C_CQ_NUM];
    logic [AD-1:0]       base_sel;
    logic [AD-1:0]       addr_sum;

    // Out-of-range ids are clamped so the muxes never index past the
    // slots; the request is still rejected through qid_ok.
    assign qid_ok = (qid_q <= QID_LAST);
    assign sel    = qid_ok ? qid_q : 4'd0;
    assign sel_oh = {{(C_CQ_NUM-1){1'b0}}, 1'b1} << sel;
    assign live   = qid_ok & cq_valid[sel] & cq_rst_n[sel];

    assign base_sel = cq_bs_addr_flat[`CQ_BW(sel, AD)];
    assign addr_sum = base_sel + {{(AD-8-CQ_ENTRY_DW_SHIFT){1'b0}},
                                  slot_tail[sel],
                                  {CQ_ENTRY_DW_SHIFT{1'b0}}};

    // A CQ reset seen while the write was outstanding suppresses the
    // tail advance and interrupt for that entry.
    assign upd_en   = (state_q == S_UPDATE) & ~skip_q & cq_rst_n[sel];
    assign slot_upd = upd_en ? sel_oh : '0;

    for (genvar n = 0; n < C_CQ_NUM; n++) begin : g_slot
        assign slot_rst_n[n] = pcie_user_rst_n & cq_rst_n[n];

        pcie_cq_tail_slot u_slot (
            .clk_i   (pcie_user_clk),
            .rst_n_i (slot_rst_n[n]),
            .upd_i   (slot_upd[n]),
            .size_i  (cq_size_flat[`CQ_B8(n)]),
            .head_i  (cq_head_ptr_flat[`CQ_B8(n)]),
            .tail_o  (slot_tail[n]),
            .phase_o (slot_phase[n]),
            .full_o  (slot_full[n])
        );

        assign cq_tail_ptr_flat[`CQ_B8(n)] = slot_tail[n];
    end

    always_ff @(posedge pcie_user_clk or negedge pcie_user_rst_n) begin
        if (!pcie_user_rst_n) begin
            state_q <= S_IDLE;
            qid_q   <= 4'd0;
            rdy_q   <= 1'b1;
            req_q   <= 1'b0;
            addr_q  <= '0;
            phase_q <= 1'b1;
            err_q   <= 1'b0;
            skip_q  <= 1'b0;
            irq_q   <= '0;
        end else begin
            err_q <= 1'b0;
            irq_q <= slot_upd;
            unique case (state_q)
                S_IDLE: begin
                    if (cpl_req && rdy_q) begin
                        qid_q   <= cpl_qid;
                        rdy_q   <= 1'b0;
                        state_q <= S_CHECK;
                    end
                end
                S_CHECK: begin
                    if (!live) begin
                        err_q   <= 1'b1;
                        rdy_q   <= 1'b1;
                        state_q <= S_IDLE;
                    end else if (!slot_full[sel]) begin
                        state_q <= S_CALC;
                    end
                end
                S_CALC: begin
                    if (!live) begin
                        err_q   <= 1'b1;
                        rdy_q   <= 1'b1;
                        state_q <= S_IDLE;
                    end else begin
                        addr_q  <= addr_sum;
                        phase_q <= slot_phase[sel];
                        skip_q  <= 1'b0;
                        req_q   <= 1'b1;
                        state_q <= S_REQ;
                    end
                end
                S_REQ: begin
                    if (!cq_rst_n[sel]) begin
                        skip_q <= 1'b1;
                    end
                    if (tx_cq_ack) begin
                        req_q   <= 1'b0;
                        state_q <= S_UPDATE;
                    end
                end
                S_UPDATE: begin
                    rdy_q   <= 1'b1;
                    state_q <= S_IDLE;
                end
                default: begin
                    rdy_q   <= 1'b1;
                    req_q   <= 1'b0;
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign cpl_rdy      = rdy_q;
    assign tx_cq_req    = req_q;
    assign tx_cq_qid    = qid_q;
    assign tx_cq_addr   = addr_q;
    assign tx_cq_phase  = phase_q;
    assign cq_irq_pulse = irq_q;
    assign cpl_err      = err_q;

endmodule

// File: tb/tb_pcie_cpl_cq_post.sv
// Self-checking bench for pcie_cpl_cq_post: directed steps plus random
// posts compared against a queue-level model of tails, phases and heads.
module tb_pcie_cpl_cq_post;

    localparam int AW = 48;
    localparam int AD = AW - 2;
    localparam int NQ = 9;

    logic              clk = 1'b0;
    logic              rst_n;
    logic [NQ-1:0]     cq_rst_n;
    logic [NQ-1:0]     cq_valid;
    logic [8*NQ-1:0]   size_flat;
    logic [8*NQ-1:0]   head_flat;
    logic [NQ*AD-1:0]  base_flat;
    logic              req;
    logic [3:0]        qid;
    logic              rdy;
    logic              tx_req;
    logic [3:0]        tx_qid;
    logic [AD-1:0]     tx_addr;
    logic              tx_phase;
    logic              ack;
    logic [8*NQ-1:0]   tail_flat;
    logic [NQ-1:0]     irq;
    logic              err;

    int checks = 0;
    int fails  = 0;

    int     m_tail  [NQ];
    int     m_phase [NQ];
    int     m_size  [NQ];
    int     m_head  [NQ];
    longint m_base  [NQ];
    bit     m_valid [NQ];

    always #5 clk = ~clk;

    pcie_cpl_cq_post #(
        .C_PCIE_DATA_WIDTH (512),
        .C_PCIE_ADDR_WIDTH (AW),
        .C_CQ_NUM          (NQ)
    ) dut (
        .pcie_user_clk    (clk),
        .pcie_user_rst_n  (rst_n),
        .cq_rst_n         (cq_rst_n),
        .cq_valid         (cq_valid),
        .cq_size_flat     (size_flat),
        .cq_head_ptr_flat (head_flat),
        .cq_bs_addr_flat  (base_flat),
        .cpl_req          (req),
        .cpl_qid          (qid),
        .cpl_rdy          (rdy),
        .tx_cq_req        (tx_req),
        .tx_cq_qid        (tx_qid),
        .tx_cq_addr       (tx_addr),
        .tx_cq_phase      (tx_phase),
        .tx_cq_ack        (ack),
        .cq_tail_ptr_flat (tail_flat),
        .cq_irq_pulse     (irq),
        .cpl_err          (err)
    );

    task automatic chk(input string tag, input logic [127:0] obs,
                       input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic drive_cfg();
        for (int n = 0; n < NQ; n++) begin
            size_flat[8*n +: 8]  = 8'(m_size[n]);
            head_flat[8*n +: 8]  = 8'(m_head[n]);
            base_flat[AD*n +: AD] = AD'(m_base[n]);
            cq_valid[n]          = m_valid[n];
        end
    endtask

    // Queue arithmetic: a ring of size+1 entries.
    function automatic int nxt(input int n);
        return (m_tail[n] + 1) % (m_size[n] + 1);
    endfunction

    function automatic bit is_full(input int n);
        return nxt(n) == m_head[n];
    endfunction

    function automatic logic [AD-1:0] exp_addr(input int n);
        return AD'(m_base[n] + longint'(m_tail[n]) * 4);
    endfunction

    task automatic model_advance(input int n);
        if (nxt(n) == 0) m_phase[n] = 1 - m_phase[n];
        m_tail[n] = nxt(n);
    endtask

    task automatic chk_tails(input string tag);
        logic [8*NQ-1:0] e;
        for (int n = 0; n < NQ; n++) e[8*n +: 8] = 8'(m_tail[n]);
        chk(tag, tail_flat, e);
    endtask

    // Present one request for one cycle; returns on the negedge after it.
    task automatic issue(input int q);
        @(negedge clk);
        chk("rdy_idle", rdy, 1'b1);
        req = 1'b1;
        qid = 4'(q);
        @(negedge clk);
        req = 1'b0;
        qid = 4'($urandom);
    endtask

    // Wait for the write request, hold ack low, optionally reset the CQ
    // during the hold, then ack and check the tail/irq update.
    task automatic complete(input int q, input int hold, input int rst_at,
                            input bit chk_lat);
        int            cyc;
        bit            dropped;
        logic [AD-1:0] a0;
        cyc = 1;
        while (tx_req !== 1'b1 && cyc < 100) begin
            @(negedge clk);
            cyc++;
        end
        chk("req_seen", tx_req, 1'b1);
        if (chk_lat) chk("latency", cyc, 3);
        a0 = exp_addr(q);
        chk("addr", tx_addr, a0);
        chk("qid", tx_qid, q);
        chk("phase", tx_phase, m_phase[q]);
        chk("rdy_busy", rdy, 1'b0);
        dropped = 1'b0;
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            chk("hold_req", tx_req, 1'b1);
            chk("hold_addr", tx_addr, a0);
            if (i == rst_at) begin
                cq_rst_n[q] = 1'b0;
                m_tail[q]   = 0;
                m_phase[q]  = 1;
                dropped     = 1'b1;
                #1;
                chk_tails("cq_rst_tail");
            end else begin
                cq_rst_n[q] = 1'b1;
            end
        end
        cq_rst_n[q] = 1'b1;
        ack = 1'b1;
        @(negedge clk);
        ack = 1'b0;
        chk("req_drop", tx_req, 1'b0);
        chk("irq_early", irq, '0);
        @(negedge clk);
        if (!dropped) model_advance(q);
        chk("irq", irq, dropped ? 9'd0 : 9'(1 << q));
        chk_tails("tails");
        chk("rdy_back", rdy, 1'b1);
        @(negedge clk);
        chk("irq_once", irq, '0);
    endtask

    task automatic err_post(input int q);
        issue(q);
        chk("err_early", err, 1'b0);
        @(negedge clk);
        chk("err_pulse", err, 1'b1);
        chk("err_rdy", rdy, 1'b1);
        chk("err_noreq", tx_req, 1'b0);
        @(negedge clk);
        chk("err_once", err, 1'b0);
    endtask

    initial begin
        int seen;
        int q;

        rst_n    = 1'b0;
        cq_rst_n = '1;
        req      = 1'b0;
        qid      = 4'd0;
        ack      = 1'b0;
        for (int n = 0; n < NQ; n++) begin
            m_tail[n]  = 0;
            m_phase[n] = 1;
            m_size[n]  = $urandom_range(1, 6);
            m_head[n]  = 0;
            m_base[n]  = (longint'($urandom) & 64'hFFFF_FFF0)
                       | (longint'(n) << 36);
            m_valid[n] = 1'b1;
        end
        m_size[1]  = 3;
        m_base[1]  = 64'h1000;
        m_valid[4] = 1'b0;
        m_size[5]  = 0;
        drive_cfg();

        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("rst_rdy", rdy, 1'b1);
        chk("rst_req", tx_req, 1'b0);
        chk("rst_irq", irq, '0);
        chk("rst_err", err, 1'b0);
        chk_tails("rst_tails");

        // Ack while idle must do nothing.
        ack = 1'b1;
        repeat (2) @(negedge clk);
        ack = 1'b0;
        chk("idle_ack_req", tx_req, 1'b0);
        chk("idle_ack_irq", irq, '0);
        chk_tails("idle_ack_tails");

        // Three posts to CQ1: 0x1000, 0x1004, 0x1008, phase 1.
        for (int i = 0; i < 3; i++) begin
            issue(1);
            complete(1, i, -1, 1'b1);
        end
        chk("cq1_tail3", tail_flat[15:8], 8'd3);

        // Tail 3, head 0: full, request stalls in the check state.
        issue(1);
        seen = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (tx_req !== 1'b0) seen++;
        end
        chk("stall_noreq", seen, 0);
        chk("stall_rdy", rdy, 1'b0);
        m_head[1] = 2;
        drive_cfg();
        complete(1, 0, -1, 1'b0);
        chk("wrap_tail", tail_flat[15:8], 8'd0);

        // After the wrap the phase flips.
        issue(1);
        complete(1, 1, -1, 1'b1);

        // Bad qid and disabled CQ are dropped with an error pulse.
        err_post(9);
        err_post(4);

        // Size-0 CQ never has room; a CQ reset while waiting drops it.
        issue(5);
        seen = 0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (tx_req !== 1'b0 || err !== 1'b0) seen++;
        end
        chk("size0_wait", seen, 0);
        cq_rst_n[5] = 1'b0;
        @(negedge clk);
        chk("size0_err", err, 1'b1);
        cq_rst_n[5] = 1'b1;
        @(negedge clk);
        chk("size0_err_once", err, 1'b0);
        chk("size0_rdy", rdy, 1'b1);
        m_size[5] = 4;
        drive_cfg();

        // Long ack stall with a CQ reset pulse while the write is pending.
        m_head[1] = 0;
        drive_cfg();
        issue(1);
        complete(1, 10, 4, 1'b1);

        // Random posts across all usable CQs.
        for (int it = 0; it < 30; it++) begin
            do q = $urandom_range(0, NQ - 1); while (q == 4);
            if ($urandom_range(0, 2) == 0)
                m_head[q] = $urandom_range(0, m_size[q]);
            if (is_full(q)) m_head[q] = m_tail[q];
            drive_cfg();
            issue(q);
            complete(q, $urandom_range(0, 3), -1, 1'b1);
        end

        // Global reset while the write request is pending.
        if (is_full(2)) m_head[2] = m_tail[2];
        drive_cfg();
        issue(2);
        seen = 0;
        while (tx_req !== 1'b1 && seen < 100) begin
            @(negedge clk);
            seen++;
        end
        chk("grst_req_seen", tx_req, 1'b1);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        for (int n = 0; n < NQ; n++) begin
            m_tail[n]  = 0;
            m_phase[n] = 1;
            m_head[n]  = 0;
        end
        chk("grst_req", tx_req, 1'b0);
        chk("grst_rdy", rdy, 1'b1);
        chk_tails("grst_tails");
        drive_cfg();
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("grst_rdy_after", rdy, 1'b1);
        chk("grst_req_after", tx_req, 1'b0);
        issue(2);
        complete(2, 1, -1, 1'b1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end

endmodule
